// File: rtl/dpram_burst_reader.sv
// Burst read engine for a single-clock simple dual-port RAM.
// Converts a (start address, length) command into RAM read strobes and
// presents the returned words as a valid/ready stream with a last marker.
// Addresses wrap modulo NUM_MEM so a circular buffer can be drained.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; rejects bad addresses, completes len==0
// RUN   | issuing reads and streaming words until last word accepted
module dpram_burst_reader #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_MEM    = 15,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_MEM - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(NUM_MEM);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  issue;
   logic                  handshake;

   // A read may only be issued when the output slot is free or being freed,
   // so the RAM's held dout is never overwritten under an unaccepted word.
   assign issue     = (state_q == S_RUN) && (rem_q != '0) && !abort &&
                      (!out_valid_q || out_ready);
   assign handshake = out_valid_q && out_ready;

   assign rd_en     = issue;
   assign raddr     = addr_q;
   assign busy      = (state_q == S_RUN);
   assign done      = done_q;
   assign err       = err_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = rdata;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Next-state logic: command acceptance in IDLE, read issue and stream
   // bookkeeping in RUN.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_addr >= DEPTH) begin
                  err_d = 1'b1;
               end else if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = start_addr;
                  rem_d   = len;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               // A word handshaking in this cycle is delivered; anything
               // still pending is simply dropped.
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               rem_d       = '0;
               state_d     = S_IDLE;
            end else begin
               if (issue) begin
                  addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
                  rem_d       = rem_q - LEN_WIDTH'(1);
                  out_valid_d = 1'b1;
                  out_last_d  = (rem_q == LEN_WIDTH'(1));
               end else if (handshake) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end
               // The last word has no read behind it, so issue cannot
               // coincide with accepting it.
               if (handshake && out_last_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Directed bench for dpram_burst_reader with a behavioural RAM preloaded
// with mem[i] = 0x100 + i.
module tb_dpram_burst_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] start_addr;
   logic [15:0] len;
   logic        abort;
   logic        busy, done, err;
   logic [31:0] raddr;
   logic        rd_en;
   logic [31:0] rdata = 32'h0;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ready;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [15];

   always #5 clk = ~clk;

   dpram_burst_reader #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MEM(15), .LEN_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .len(len), .abort(abort), .busy(busy), .done(done), .err(err),
      .raddr(raddr), .rd_en(rd_en), .rdata(rdata), .out_valid(out_valid),
      .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
   );

   // RAM read port: dout updates only on a strobe, otherwise holds.
   always @(posedge clk) begin
      if (rd_en) rdata <= mem[raddr[3:0]];
   end

   typedef struct {
      logic        st;
      logic [31:0] sa;
      logic [15:0] ln;
      logic        rdy;
      logic        busy;
      logic        rd;
      logic [31:0] ra;
      logic        v;
      logic [31:0] d;
      logic        last;
      logic        done;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic st, logic [31:0] sa, logic [15:0] ln, logic rdy,
                               logic b, logic rd, logic [31:0] ra, logic v,
                               logic [31:0] d, logic last, logic dn, logic er);
      vec_t r;
      r.st = st; r.sa = sa; r.ln = ln; r.rdy = rdy;
      r.busy = b; r.rd = rd; r.ra = ra; r.v = v; r.d = d;
      r.last = last; r.done = dn; r.err = er;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic [31:0] sa, input logic [15:0] ln,
                        input logic ab, input logic rdy);
      start = st; start_addr = sa; len = ln; abort = ab; out_ready = rdy;
   endtask

   initial begin
      for (int i = 0; i < 15; i++) mem[i] = 32'h100 + i;
      rst = 1'b1;
      drive(0, 0, 0, 0, 1);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_last", out_last, 0);
      chk("reset_rd_en", rd_en, 0);
      chk("reset_raddr", raddr, 0);
      #20;
      rst = 1'b0;
      step();

      // Basic burst, back-to-back wrap burst, len==0, bad address, stalled burst
      tbl.push_back(mk(1, 3, 4, 1,  0,0, 0,   0,0,      0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 3,   0,0,      0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 4,   1,'h103,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 5,   1,'h104,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 6,   1,'h105,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,0, 0,   1,'h106,  1,0,0));
      tbl.push_back(mk(1, 13,4, 1,  0,0, 0,   0,0,      0,1,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 13,  0,0,      0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 14,  1,'h10D,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 0,   1,'h10E,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 1,   1,'h100,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,0, 0,   1,'h101,  1,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  0,0, 0,   0,0,      0,1,0));
      tbl.push_back(mk(1, 2, 0, 1,  0,0, 0,   0,0,      0,0,0));
      tbl.push_back(mk(1, 15,5, 1,  0,0, 0,   0,0,      0,1,0));
      tbl.push_back(mk(0, 0, 0, 1,  0,0, 0,   0,0,      0,0,1));
      tbl.push_back(mk(1, 0, 3, 1,  0,0, 0,   0,0,      0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 0,   0,0,      0,0,0));
      tbl.push_back(mk(0, 0, 0, 0,  1,0, 0,   1,'h100,  0,0,0));
      tbl.push_back(mk(1, 5, 2, 0,  1,0, 0,   1,'h100,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 1,   1,'h100,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 0,  1,0, 0,   1,'h101,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 0,  1,0, 0,   1,'h101,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,1, 2,   1,'h101,  0,0,0));
      tbl.push_back(mk(0, 0, 0, 0,  1,0, 0,   1,'h102,  1,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  1,0, 0,   1,'h102,  1,0,0));
      tbl.push_back(mk(0, 0, 0, 1,  0,0, 0,   0,0,      0,1,0));
      tbl.push_back(mk(0, 0, 0, 1,  0,0, 0,   0,0,      0,0,0));

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sa, tbl[i].ln, 0, tbl[i].rdy);
         #1;
         chk($sformatf("c%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("c%0d_rd_en", i), rd_en, tbl[i].rd);
         chk($sformatf("c%0d_valid", i), out_valid, tbl[i].v);
         chk($sformatf("c%0d_last", i), out_last, tbl[i].last);
         chk($sformatf("c%0d_done", i), done, tbl[i].done);
         chk($sformatf("c%0d_err", i), err, tbl[i].err);
         if (tbl[i].rd) chk($sformatf("c%0d_raddr", i), raddr, tbl[i].ra);
         if (tbl[i].v)  chk($sformatf("c%0d_data", i), out_data, tbl[i].d);
         step();
      end

      // Abort in cycle 4 of an 8-word burst, then a normal 1-word burst
      drive(1, 0, 8, 0, 1); #1; step();
      drive(0, 0, 0, 0, 1); step(); step(); step();
      drive(0, 0, 0, 1, 1); #1;
      chk("abort_rd_en", rd_en, 0);
      chk("abort_busy", busy, 1);
      step();
      drive(0, 0, 0, 0, 1); #1;
      chk("post_abort_valid", out_valid, 0);
      chk("post_abort_busy", busy, 0);
      chk("post_abort_done", done, 0);
      step();
      chk("post_abort_done2", done, 0);
      drive(1, 2, 1, 0, 1); #1; step();
      drive(0, 0, 0, 0, 1); #1;
      chk("after_abort_rd_en", rd_en, 1);
      chk("after_abort_raddr", raddr, 2);
      step();
      chk("after_abort_data", out_data, 32'h102);
      chk("after_abort_last", out_last, 1);
      step();
      chk("after_abort_done", done, 1);
      step();

      // Asynchronous reset in the middle of a burst
      drive(1, 0, 8, 0, 1); #1; step();
      drive(0, 0, 0, 0, 1); step(); step();
      chk("pre_rst_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_en", rd_en, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_last", out_last, 0);
      chk("midrst_raddr", raddr, 0);
      chk("midrst_done", done, 0);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
